branch_predictor_2way: RTL

BRANCH_PREDICTOR_2WAY -- requirements
Module: branch_predictor_2way

---
 rtl/branch_predictor_2way_pkg.sv | 20 ++
 rtl/branch_predictor_2way_sat_counter2.sv | 20 ++
 rtl/branch_predictor_2way.sv | 113 +++++++++++
 3 files changed

// File: rtl/branch_predictor_2way_pkg.sv
// Shared core definitions for the two-slot branch predictor: table geometry
// and the 2-bit saturating counter encoding.
package branch_predictor_2way_pkg;

    localparam int PC_W  = 9;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    // Counter given to an entry freshly allocated by a resolving branch.
    function automatic ctr_t alloc_ctr(input logic taken);
        return taken ? WT : WNT;
    endfunction

endpackage

// File: rtl/branch_predictor_2way_sat_counter2.sv
// One step of a 2-bit saturating counter: up on taken, down on not-taken.
module sat_counter2
    import branch_predictor_2way_pkg::*;
(
    input  ctr_t value,
    input  logic taken,
    output ctr_t next_value
);

    always_comb begin
        // NOTE: combinational blocks assign a default first so no path infers a latch.
        next_value = value;
        if (taken && value != ST) begin
            next_value = ctr_t'(value + 2'd1);
        end else if (!taken && value != SNT) begin
            next_value = ctr_t'(value - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor_2way.sv
// Direct-mapped, tagged branch target table with 2-bit counters, looked up by
// two fetch slots and trained by two resolving slots per cycle.
module branch_predictor_2way #(
    parameter int PC_W  = branch_predictor_2way_pkg::PC_W,
    parameter int IDX_W = branch_predictor_2way_pkg::IDX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] PCF1,
    input  logic [PC_W-1:0] PCF2,
    output logic            PredictionF1,
    output logic            PredictionF2,
    output logic [PC_W-1:0] PredTargetF1,
    output logic [PC_W-1:0] PredTargetF2,
    input  logic            UpdateEn1,
    input  logic            UpdateEn2,
    input  logic [PC_W-1:0] PCM1,
    input  logic [PC_W-1:0] PCM2,
    input  logic            branch_taken1,
    input  logic            branch_taken2,
    input  logic [PC_W-1:0] branchAdderResultM1,
    input  logic [PC_W-1:0] branchAdderResultM2,
    input  logic            PredictionM1,
    input  logic            PredictionM2,
    output logic [15:0]     MispredictCount
);

    import branch_predictor_2way_pkg::*;

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    ctr_t             ctr_q    [ENTRIES];

    logic [IDX_W-1:0] idx_f1, idx_f2, idx_m1, idx_m2;
    logic [TAG_W-1:0] tag_m1, tag_m2;
    logic             hit_f1, hit_f2, hit_m1, hit_m2;

    assign idx_f1 = PCF1[IDX_W-1:0];
    assign idx_f2 = PCF2[IDX_W-1:0];
    assign idx_m1 = PCM1[IDX_W-1:0];
    assign idx_m2 = PCM2[IDX_W-1:0];
    assign tag_m1 = PCM1[PC_W-1:IDX_W];
    assign tag_m2 = PCM2[PC_W-1:IDX_W];

    assign hit_f1 = valid_q[idx_f1] && (tag_q[idx_f1] == PCF1[PC_W-1:IDX_W]);
    assign hit_f2 = valid_q[idx_f2] && (tag_q[idx_f2] == PCF2[PC_W-1:IDX_W]);
    assign hit_m1 = valid_q[idx_m1] && (tag_q[idx_m1] == tag_m1);
    assign hit_m2 = valid_q[idx_m2] && (tag_q[idx_m2] == tag_m2);

    // Lookup reads the registered table only, so same-cycle updates are invisible.
    assign PredictionF1 = rst && hit_f1 && (ctr_q[idx_f1] inside {WT, ST});
    assign PredictionF2 = rst && hit_f2 && (ctr_q[idx_f2] inside {WT, ST});
    assign PredTargetF1 = PredictionF1 ? target_q[idx_f1] : PCF1 + PC_W'(1);
    assign PredTargetF2 = PredictionF2 ? target_q[idx_f2] : PCF2 + PC_W'(1);

    ctr_t step1, step2, chained, ctr_new1, ctr_new2;
    logic same_idx;

    sat_counter2 u_step1 (.value(ctr_q[idx_m1]), .taken(branch_taken1), .next_value(step1));
    sat_counter2 u_step2 (.value(ctr_q[idx_m2]), .taken(branch_taken2), .next_value(step2));
    sat_counter2 u_chain (.value(ctr_new1),      .taken(branch_taken2), .next_value(chained));

    assign same_idx = UpdateEn1 && (idx_m1 == idx_m2);
    assign ctr_new1 = hit_m1 ? step1 : alloc_ctr(branch_taken1);

    // Slot 2 sees the entry as slot 1 just left it when both hit one index.
    always_comb begin
        ctr_new2 = hit_m2 ? step2 : alloc_ctr(branch_taken2);
        if (same_idx) begin
            ctr_new2 = (tag_m1 == tag_m2) ? chained : alloc_ctr(branch_taken2);
        end
    end

    logic        mis1, mis2;
    logic [16:0] count_sum;

    assign mis1      = UpdateEn1 && (branch_taken1 != PredictionM1);
    assign mis2      = UpdateEn2 && (branch_taken2 != PredictionM2);
    assign count_sum = {1'b0, MispredictCount} + 17'(mis1) + 17'(mis2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the table is registers, not RAM, so every entry can be cleared by reset.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            MispredictCount <= '0;
        end else begin
            // NOTE: non-blocking writes; on a shared index slot 2's later assignments win.
            if (UpdateEn1) begin
                valid_q[idx_m1] <= 1'b1;
                tag_q[idx_m1]   <= tag_m1;
                ctr_q[idx_m1]   <= ctr_new1;
                if (branch_taken1) target_q[idx_m1] <= branchAdderResultM1;
            end
            if (UpdateEn2) begin
                valid_q[idx_m2] <= 1'b1;
                tag_q[idx_m2]   <= tag_m2;
                ctr_q[idx_m2]   <= ctr_new2;
                if (branch_taken2) target_q[idx_m2] <= branchAdderResultM2;
            end
            MispredictCount <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end

endmodule
